// File: rtl/fft_r2_inplace_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_r2_inplace_addr_gen: read/twiddle/write-back address sequencer for an   |
// | in-place radix-2 FFT on one single-port data RAM. Rev 1.0                  |
// +----------------------------------------------------------------------------+
module fft_r2_inplace_addr_gen #(
    parameter int LOG2N   = 4,
    parameter int TW_BITS = 10,
    parameter int WR_LAT  = 3,
    parameter int SW      = $clog2(LOG2N + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               dir_i,
    input  logic               inv_i,
    input  logic               stall_i,
    output logic               rd_en_o,
    output logic [LOG2N-1:0]   rd_addr_o,
    output logic [TW_BITS-1:0] tw_addr_o,
    output logic               wr_en_o,
    output logic [LOG2N-1:0]   wr_addr_o,
    output logic [SW-1:0]      stage_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int               c_n          = 1 << LOG2N;
    localparam logic [LOG2N-1:0] c_last_bf    = LOG2N'(c_n / 2 - 1);
    localparam logic [3:0]       c_drain_last = 4'(WR_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [LOG2N-1:0]   bf_q, bf_d;
    logic [3:0]         drain_q, drain_d;
    logic               dir_q, dir_d;
    logic               inv_q, inv_d;
    logic               rd_en_q, rd_en_d;
    logic [LOG2N-1:0]   rd_addr_q, rd_addr_d;
    logic [TW_BITS-1:0] tw_addr_q, tw_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_en_pipe_q   [WR_LAT];
    logic               wr_en_pipe_d   [WR_LAT];
    logic [LOG2N-1:0]   wr_addr_pipe_q [WR_LAT];
    logic [LOG2N-1:0]   wr_addr_pipe_d [WR_LAT];

    logic               last_stage;
    logic [LOG2N-1:0]   span;
    logic [LOG2N-1:0]   k_mask;
    logic [LOG2N-1:0]   k_idx;
    logic [LOG2N-1:0]   lo_addr;
    logic [TW_BITS-1:0] tw_raw;
    int                 tw_sh;

    assign last_stage = dir_q ? (stage_q == SW'(1)) : (stage_q == SW'(LOG2N));

    // Sequencing: every transition is suppressed while stalled.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bf_d    = bf_q;
        drain_d = drain_q;
        dir_d   = dir_q;
        inv_d   = inv_q;
        if (!stall_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_RD_A;
                        dir_d   = dir_i;
                        inv_d   = inv_i;
                        stage_d = dir_i ? SW'(LOG2N) : SW'(1);
                        bf_d    = '0;
                    end
                end
                S_RD_A: state_d = S_RD_B;
                S_RD_B: begin
                    if (bf_q == c_last_bf) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        state_d = S_RD_A;
                        bf_d    = bf_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == c_drain_last) begin
                        if (last_stage) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RD_A;
                            stage_d = dir_q ? stage_q - 1'b1 : stage_q + 1'b1;
                            bf_d    = '0;
                        end
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    stage_d = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Butterfly index j maps to a = g*2h + k by inserting a zero at bit s-1.
    always_comb begin
        span    = LOG2N'(1) << (stage_d - SW'(1));
        k_mask  = span - 1'b1;
        k_idx   = bf_d & k_mask;
        lo_addr = ((bf_d & ~k_mask) << 1) | k_idx;
        tw_sh   = TW_BITS - int'(stage_d);
        tw_raw  = TW_BITS'(k_idx) << tw_sh;
    end

    always_comb begin
        rd_en_d   = (state_d == S_RD_A) || (state_d == S_RD_B);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        rd_addr_d = rd_addr_q;
        tw_addr_d = tw_addr_q;
        if (state_d == S_RD_A) begin
            rd_addr_d = lo_addr;
            tw_addr_d = inv_d ? -tw_raw : tw_raw;
        end else if (state_d == S_RD_B) begin
            rd_addr_d = lo_addr | span;
        end
    end

    always_comb begin
        for (int i = 0; i < WR_LAT; i++) begin
            wr_en_pipe_d[i]   = wr_en_pipe_q[i];
            wr_addr_pipe_d[i] = wr_addr_pipe_q[i];
        end
        if (!stall_i) begin
            wr_en_pipe_d[0]   = rd_en_q;
            wr_addr_pipe_d[0] = rd_addr_q;
            for (int i = 1; i < WR_LAT; i++) begin
                wr_en_pipe_d[i]   = wr_en_pipe_q[i-1];
                wr_addr_pipe_d[i] = wr_addr_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            stage_q   <= '0;
            bf_q      <= '0;
            drain_q   <= '0;
            dir_q     <= 1'b0;
            inv_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            tw_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < WR_LAT; i++) begin
                wr_en_pipe_q[i]   <= 1'b0;
                wr_addr_pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            bf_q      <= bf_d;
            drain_q   <= drain_d;
            dir_q     <= dir_d;
            inv_q     <= inv_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            tw_addr_q <= tw_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int i = 0; i < WR_LAT; i++) begin
                wr_en_pipe_q[i]   <= wr_en_pipe_d[i];
                wr_addr_pipe_q[i] <= wr_addr_pipe_d[i];
            end
        end
    end

    // Strobes are masked in the stalled cycle itself so nothing is consumed twice.
    assign rd_en_o   = rd_en_q & ~stall_i;
    assign wr_en_o   = wr_en_pipe_q[WR_LAT-1] & ~stall_i;
    assign done_o    = done_q & ~stall_i;
    assign rd_addr_o = rd_addr_q;
    assign tw_addr_o = tw_addr_q;
    assign wr_addr_o = wr_addr_pipe_q[WR_LAT-1];
    assign stage_o   = stage_q;
    assign busy_o    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_r2_inplace_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_r2_inplace_addr_gen: directed self-checking bench for the FFT       |
// | address generator (N=16 main instance, N=2 small instance). Rev 1.0        |
// +----------------------------------------------------------------------------+
module tb_fft_r2_inplace_addr_gen;

    localparam int LOG2N   = 4;
    localparam int TW_BITS = 10;
    localparam int WR_LAT  = 3;
    localparam int SW      = 3;
    localparam int N       = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start_i = 1'b0;
    logic               dir_i = 1'b0;
    logic               inv_i = 1'b0;
    logic               stall_i = 1'b0;
    logic               rd_en_o, wr_en_o, busy_o, done_o;
    logic [LOG2N-1:0]   rd_addr_o, wr_addr_o;
    logic [TW_BITS-1:0] tw_addr_o;
    logic [SW-1:0]      stage_o;

    logic               s_start = 1'b0;
    logic               s_rd_en, s_wr_en, s_busy, s_done;
    logic [0:0]         s_rd_addr, s_wr_addr, s_stage;
    logic [9:0]         s_tw;

    int n_checks = 0;
    int n_errors = 0;

    int rd_q[$], tw_q[$], st_q[$], rd_act[$], wr_q[$], wr_act[$];
    int exp_rd[$], exp_tw[$], exp_st[$];

    always #5 clk = ~clk;

    fft_r2_inplace_addr_gen #(.LOG2N(LOG2N), .TW_BITS(TW_BITS), .WR_LAT(WR_LAT), .SW(SW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .dir_i(dir_i), .inv_i(inv_i),
        .stall_i(stall_i), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .tw_addr_o(tw_addr_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .stage_o(stage_o), .busy_o(busy_o),
        .done_o(done_o)
    );

    fft_r2_inplace_addr_gen #(.LOG2N(1), .TW_BITS(10), .WR_LAT(1), .SW(1)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .dir_i(1'b0), .inv_i(1'b0),
        .stall_i(1'b0), .rd_en_o(s_rd_en), .rd_addr_o(s_rd_addr), .tw_addr_o(s_tw),
        .wr_en_o(s_wr_en), .wr_addr_o(s_wr_addr), .stage_o(s_stage), .busy_o(s_busy),
        .done_o(s_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int get(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Reference stream straight from the g/k loop nest.
    task automatic build_exp(input bit dir, input bit inv);
        int s, h, t;
        exp_rd.delete(); exp_tw.delete(); exp_st.delete();
        for (int si = 0; si < LOG2N; si++) begin
            s = dir ? LOG2N - si : si + 1;
            h = 1 << (s - 1);
            for (int g = 0; g < N / (2 * h); g++) begin
                for (int k = 0; k < h; k++) begin
                    t = k << (TW_BITS - s);
                    if (inv) t = (1024 - t) % 1024;
                    exp_rd.push_back(g * 2 * h + k);     exp_tw.push_back(t); exp_st.push_back(s);
                    exp_rd.push_back(g * 2 * h + k + h); exp_tw.push_back(t); exp_st.push_back(s);
                end
            end
        end
    endtask

    task automatic run_xform(input bit dir, input bit inv, input int stall_at,
                             input int stall_len, input int poke_at, output int done_cyc);
        int act;
        rd_q.delete(); tw_q.delete(); st_q.delete(); rd_act.delete(); wr_q.delete(); wr_act.delete();
        @(posedge clk); #1;
        start_i = 1'b1; dir_i = dir; inv_i = inv;
        @(posedge clk); #1;
        start_i = 1'b0; dir_i = ~dir; inv_i = ~inv;
        act = 0;
        done_cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            stall_i = (c >= stall_at) && (c < stall_at + stall_len);
            start_i = (c == poke_at);
            @(negedge clk);
            if (c == 1) begin
                chk("busy_first", busy_o, 1);
                chk("stage_first", stage_o, dir ? 4 : 1);
            end
            if (stall_i) begin
                chk("stall_rd_en", rd_en_o, 0);
                chk("stall_wr_en", wr_en_o, 0);
            end else begin
                if (rd_en_o) begin
                    rd_q.push_back(int'(rd_addr_o)); tw_q.push_back(int'(tw_addr_o));
                    st_q.push_back(int'(stage_o));   rd_act.push_back(act);
                end
                if (wr_en_o) begin
                    wr_q.push_back(int'(wr_addr_o)); wr_act.push_back(act);
                end
                act++;
            end
            if (done_o) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        stall_i = 1'b0;
        start_i = 1'b0;
        chk("busy_at_done", busy_o, 1);
        @(negedge clk);
        chk("idle_busy", busy_o, 0);
        chk("idle_stage", stage_o, 0);
        chk("idle_done", done_o, 0);
    endtask

    task automatic check_streams(input bit dir, input bit inv, input int exp_done, input int done_cyc);
        build_exp(dir, inv);
        chk("done_cycle", done_cyc, exp_done);
        chk("rd_count", rd_q.size(), exp_rd.size());
        chk("wr_count", wr_q.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size(); i++) begin
            chk("rd_addr", get(rd_q, i), exp_rd[i]);
            chk("tw_addr", get(tw_q, i), exp_tw[i]);
            chk("stage", get(st_q, i), exp_st[i]);
            chk("wr_addr", get(wr_q, i), exp_rd[i]);
            chk("wr_delay", get(wr_act, i), get(rd_act, i) + WR_LAT);
        end
    endtask

    initial begin
        int dc;
        int ndone;

        #12;
        chk("rst_rd_en", rd_en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_stage", stage_o, 0);
        chk("rst_wr_en", wr_en_o, 0);
        chk("rst_done", done_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // DIT forward
        run_xform(1'b0, 1'b0, 0, 0, 0, dc);
        check_streams(1'b0, 1'b0, 77, dc);
        chk("dit_s1_rd3", get(rd_q, 3), 3);
        chk("dit_s4_rd1", get(rd_q, 49), 8);
        chk("dit_s4_rd2", get(rd_q, 50), 1);
        chk("dit_s4_tw2", get(tw_q, 50), 64);
        chk("dit_s4_rd63", get(rd_q, 63), 15);
        chk("dit_s4_tw63", get(tw_q, 63), 448);

        // DIF forward
        run_xform(1'b1, 1'b0, 0, 0, 0, dc);
        check_streams(1'b1, 1'b0, 77, dc);
        chk("dif_s4_rd1", get(rd_q, 1), 8);
        chk("dif_s4_tw2", get(tw_q, 2), 64);
        chk("dif_first_stage", get(st_q, 0), 4);
        chk("dif_last_stage", get(st_q, 63), 1);
        chk("dif_s1_rd49", get(rd_q, 49), 1);

        // DIT inverse
        run_xform(1'b0, 1'b1, 0, 0, 0, dc);
        check_streams(1'b0, 1'b1, 77, dc);
        chk("inv_s4_k0", get(tw_q, 48), 0);
        chk("inv_s4_k1", get(tw_q, 50), 960);
        chk("inv_s3_k3", get(tw_q, 38), 640);

        // three-cycle stall inside stage 2
        run_xform(1'b0, 1'b0, 25, 3, 0, dc);
        check_streams(1'b0, 1'b0, 80, dc);

        // stray start while busy
        run_xform(1'b0, 1'b0, 0, 0, 10, dc);
        check_streams(1'b0, 1'b0, 77, dc);

        // asynchronous abort during stage 3
        @(posedge clk); #1;
        start_i = 1'b1; dir_i = 1'b0; inv_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 0; c < 200 && stage_o != 3'd3; c++) @(negedge clk);
        @(negedge clk);
        chk("abort_in_s3", stage_o, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rd_en", rd_en_o, 0);
        chk("abort_rd_addr", rd_addr_o, 0);
        chk("abort_tw", tw_addr_o, 0);
        chk("abort_wr_en", wr_en_o, 0);
        chk("abort_wr_addr", wr_addr_o, 0);
        chk("abort_stage", stage_o, 0);
        chk("abort_busy", busy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done_o || busy_o) ndone++;
        end
        chk("abort_quiet", ndone, 0);
        run_xform(1'b1, 1'b1, 0, 0, 0, dc);
        check_streams(1'b1, 1'b1, 77, dc);

        // N=2, WR_LAT=1 instance
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        @(negedge clk);
        chk("n2_c1_rd_en", s_rd_en, 1);
        chk("n2_c1_rd_addr", s_rd_addr, 0);
        chk("n2_c1_tw", s_tw, 0);
        chk("n2_c1_wr_en", s_wr_en, 0);
        @(negedge clk);
        chk("n2_c2_rd_en", s_rd_en, 1);
        chk("n2_c2_rd_addr", s_rd_addr, 1);
        chk("n2_c2_tw", s_tw, 0);
        chk("n2_c2_wr_en", s_wr_en, 1);
        chk("n2_c2_wr_addr", s_wr_addr, 0);
        @(negedge clk);
        chk("n2_c3_rd_en", s_rd_en, 0);
        chk("n2_c3_wr_en", s_wr_en, 1);
        chk("n2_c3_wr_addr", s_wr_addr, 1);
        chk("n2_c3_done", s_done, 0);
        @(negedge clk);
        chk("n2_c4_done", s_done, 1);
        chk("n2_c4_busy", s_busy, 1);
        chk("n2_c4_wr_en", s_wr_en, 0);
        @(negedge clk);
        chk("n2_c5_done", s_done, 0);
        chk("n2_c5_busy", s_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_r2_inplace_addr_gen.md
Name: fft_r2_inplace_addr_gen

Overview:
Self-sequencing address generator for an in-place radix-2 FFT that uses one single-port data RAM and a full-circle twiddle ROM.
- Runs all LOG2N stages from a single start pulse, in either DIT or DIF stage order.
- Emits the two operand read addresses of each butterfly on consecutive cycles, plus the twiddle ROM address.
- Emits the matching write-back addresses, delayed by the butterfly pipeline latency.
- Supports inverse transform (conjugate twiddle), downstream stall, and inter-stage drain, so a stage never reads data the previous stage has not yet written.

Parameters:
LOG2N, 4, log2 of FFT length N; legal range 1..12.
TW_BITS, 10, twiddle ROM address width; the ROM holds one full circle of 2^TW_BITS points; must be >= LOG2N.
WR_LAT, 3, butterfly pipeline latency in active cycles from read address to write address; legal range 1..15.
SW, $clog2(LOG2N+1), width of the stage field.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_i  in  1  start the transform; sampled only in IDLE.
dir_i  in  1  stage order: 0 = DIT (span 1 -> N/2), 1 = DIF (span N/2 -> 1); latched at start.
inv_i  in  1  1 = inverse transform (negated twiddle angle); latched at start.
stall_i  in  1  freezes all sequencing while high.
rd_en_o  out  1  read address valid.
rd_addr_o  out  LOG2N  data RAM read address.
tw_addr_o  out  TW_BITS  twiddle ROM address.
wr_en_o  out  1  write-back address valid.
wr_addr_o  out  LOG2N  data RAM write address.
stage_o  out  SW  current stage s, 1..LOG2N; 0 when idle.
busy_o  out  1  high from the start edge until the done cycle, inclusive.
done_o  out  1  one-cycle pulse after the final write of the last stage.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, write delay line cleared. Reset asserted mid-transform aborts immediately; no done_o is produced.
- FSM states: IDLE, RD_A, RD_B, DRAIN, DONE. All outputs are registered and driven from the next-state value.
- IDLE -> RD_A on start_i=1. start_i is ignored in all other states. The latches dir and inv are captured on that edge.
- Stage s has span h = 2^(s-1). In DIT, s runs 1..LOG2N; in DIF, s runs LOG2N..1.
- Butterfly enumeration per stage:
  - group g = 0..N/(2h)-1 is the outer loop; k = 0..h-1 is the inner loop.
  - lower address a = g*2h + k.
  - N/2 butterflies per stage, giving N read cycles per stage.
- RD_A: rd_addr_o = a, rd_en_o = 1.
  - tw_addr_o = k << (TW_BITS - s).
  - If inv, tw_addr_o = (2^TW_BITS - that value) mod 2^TW_BITS.
- RD_B: rd_addr_o = a + h, rd_en_o = 1; tw_addr_o holds its RD_A value.
- RD_B -> RD_A for the next butterfly. After the last butterfly of the stage, RD_B -> DRAIN.
- DRAIN: rd_en_o = 0. Lasts WR_LAT active cycles so the last write of the stage completes.
  - Then -> RD_A of the next stage, or -> DONE after the final stage.
- DONE: done_o = 1 for one cycle, busy_o = 1; then -> IDLE with stage_o = 0.
- Write path: (rd_en_o, rd_addr_o) goes through a WR_LAT-deep shift register.
  - The register advances only when stall_i = 0.
  - Its output drives (wr_en_o, wr_addr_o). Writes are in place: every wr_addr equals a read address issued WR_LAT active cycles earlier.
- Stall: while stall_i = 1, the FSM, counters, twiddle and delay line hold; rd_en_o and wr_en_o are forced to 0; addresses hold their values. On release the sequence resumes with no skipped or repeated address. Stall during DRAIN extends DRAIN. Stall during DONE delays the done pulse.
- Timing: the first rd_en_o is high in the cycle after the edge that samples start_i.
  - Unstalled total = LOG2N*(N + WR_LAT) cycles of RD_A/RD_B/DRAIN, plus 1 DONE cycle.
- Arithmetic: address sums are computed in LOG2N bits and cannot overflow by construction. The twiddle shift amount TW_BITS - s is always >= 0.

Test Plan:
1. N=16, WR_LAT=3, DIT, start pulse -> stage 1 reads 0,1,2,3,...,15 with tw all 0; stage 4 reads 0,8,1,9,...,7,15 with tw 0,0,64,64,...,448,448; done_o after exactly 76 cycles of RD_A/RD_B/DRAIN plus 1 DONE cycle.
2. DIF -> first stage span 8, identical to DIT stage 4 sequence; last stage reads 0,1,...; stage_o goes 4,3,2,1.
3. inv_i=1, DIT stage 4 -> k=1 tw = 960; k=0 tw = 0 (no 1024 wrap); stage 3, k=3 tw = 1024 - 384 = 640.
4. Drive stall_i high for 3 cycles mid-stage 2 -> rd_en_o and wr_en_o are 0 for those cycles; the full read address stream equals the unstalled stream; wr_addr_o stream equals rd_addr_o stream delayed by 3 active cycles.
5. Pulse start_i while busy -> ignored, sequence unchanged. Assert rst_n low during stage 3 -> all outputs 0 asynchronously; a new start runs a clean full transform.
6. LOG2N=1, WR_LAT=1 -> reads 0,1 with tw 0; one write pair; done_o in cycle 4.
